// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that streams a granted requester's byte buffer into a
// uart_tx, one byte per start/busy handshake, with an acknowledge timeout.
module uart_tx_scheduler #(
  parameter int MAX_LEN     = 48,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [5:0] len0,
  input  logic [5:0] len1,
  output logic [5:0] rd_addr,
  input  logic [7:0] rd_data0,
  input  logic [7:0] rd_data1,
  output logic [1:0] grant,
  output logic [1:0] done,
  output logic       err,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       busy
);

  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [5:0]    MAX_LEN_L = 6'(MAX_LEN);
  localparam logic [TW-1:0] T_LAST    = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, WAIT_IDLE, START, NEXT, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [1:0]    done_q, done_d;
  logic          err_q, err_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [5:0]    rd_addr_q, rd_addr_d;
  logic [5:0]    idx_q, idx_d;
  logic [5:0]    len_q, len_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          last_q, last_d;

  logic          pick1;
  logic [5:0]    len_req;
  logic [5:0]    len_clamped;

  // last_q=1 means requester 1 was served last, so a tie goes to requester 0
  always_comb begin
    pick1 = 1'b0;
    if (req == 2'b10)
      pick1 = 1'b1;
    else if (req == 2'b11)
      pick1 = ~last_q;
    len_req     = pick1 ? len1 : len0;
    len_clamped = (len_req > MAX_LEN_L) ? MAX_LEN_L : len_req;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    done_d     = 2'b00;
    err_d      = 1'b0;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    rd_addr_d  = rd_addr_q;
    idx_d      = idx_q;
    len_d      = len_q;
    tcnt_d     = tcnt_q;
    last_d     = last_q;

    unique case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          grant_d   = pick1 ? 2'b10 : 2'b01;
          len_d     = len_clamped;
          idx_d     = 6'd0;
          rd_addr_d = 6'd0;
          state_d   = (len_clamped == 6'd0) ? DONE : FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        tx_data_d = grant_q[1] ? rd_data1 : rd_data0;
        state_d   = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tcnt_d     = '0;
          state_d    = START;
        end
      end
      START: begin
        if (tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = NEXT;
        end else if (tcnt_q == T_LAST) begin
          // uart never acknowledged: drop the frame but keep fairness moving
          tx_start_d = 1'b0;
          err_d      = 1'b1;
          last_d     = grant_q[1];
          grant_d    = 2'b00;
          state_d    = IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      NEXT: begin
        if (idx_q == len_q - 6'd1) begin
          state_d = DONE;
        end else begin
          idx_d     = idx_q + 6'd1;
          rd_addr_d = idx_q + 6'd1;
          state_d   = FETCH;
        end
      end
      DONE: begin
        done_d  = grant_q;
        last_d  = grant_q[1];
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= 2'b00;
      done_q     <= 2'b00;
      err_q      <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      rd_addr_q  <= 6'd0;
      idx_q      <= 6'd0;
      len_q      <= 6'd0;
      tcnt_q     <= '0;
      last_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      err_q      <= err_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      rd_addr_q  <= rd_addr_d;
      idx_q      <= idx_d;
      len_q      <= len_d;
      tcnt_q     <= tcnt_d;
      last_q     <= last_d;
    end
  end

  // busy stays up through the done pulse so a frame reads as finished only once done is seen
  assign busy     = (state_q != IDLE) || (done_q != 2'b00);
  assign grant    = grant_q;
  assign done     = done_q;
  assign err      = err_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign rd_addr  = rd_addr_q;

endmodule
